// File: rtl/wishbone_board_mem_dp_pkg.sv
// Shared definitions for the Minesweeper board memory.
// Cell layout, board limits and the clear-sweep state type.
package wishbone_board_mem_dp_pkg;

    localparam int BOARD_MAX_SIZE = 16;
    localparam int BOARD_IDX_W = $clog2(BOARD_MAX_SIZE);

    typedef logic [BOARD_IDX_W-1:0] board_idx_t;

    typedef struct packed {
        logic       mine;
        logic       flag;
        logic       open;
        logic [4:0] adj;
    } field_t;

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } sweep_state_t;

endpackage

// File: rtl/wishbone_if.sv
// Pipelined Wishbone bundle, signal names seen from the master side.
// The slave modport receives the *_o signals and drives the *_i ones.
interface wishbone_if #(
    parameter int ADR_W = 32,
    parameter int DAT_W = 16
);
    logic [ADR_W-1:0] adr_o;
    logic [DAT_W-1:0] dat_o;
    logic             we_o;
    logic             cyc_o;
    logic             stb_o;
    logic [DAT_W-1:0] dat_i;
    logic             ack_i;
    logic             stall_i;

    modport slave (
        input  adr_o, dat_o, we_o, cyc_o, stb_o,
        output dat_i, ack_i, stall_i
    );

    modport master (
        output adr_o, dat_o, we_o, cyc_o, stb_o,
        input  dat_i, ack_i, stall_i
    );
endinterface

// File: rtl/board_mem_ram.sv
// One write port, two registered read ports; array itself is never reset.
// Reads return the pre-write contents when addresses collide.
module board_mem_ram #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re_a,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Port A only updates on a read so the bus data holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (re_a) begin
                rdata_a <= mem[raddr_a];
            end
            rdata_b <= mem[raddr_b];
        end
    end
endmodule

// File: rtl/wishbone_board_mem_dp.sv
// Board memory: Wishbone slave for game logic, read port for display,
// and a one-cell-per-cycle clear sweep that stalls the bus while running.
module wishbone_board_mem_dp
    import wishbone_board_mem_dp_pkg::*;
#(
    parameter int MAX_SIZE = BOARD_MAX_SIZE,
    parameter int FIELD_W = $bits(field_t),
    parameter int DAT_W = 16,
    parameter int ADR_W = 32,
    localparam int IDX_W = $clog2(MAX_SIZE)
) (
    input  logic               clk,
    input  logic               rst,
    wishbone_if.slave          slave,
    input  logic [IDX_W:0]     board_size,
    input  logic               clear_req,
    input  logic [IDX_W-1:0]   rd_row,
    input  logic [IDX_W-1:0]   rd_col,
    output logic [FIELD_W-1:0] rd_data,
    output logic               busy
);
    localparam int AW = 2 * IDX_W;
    localparam logic [AW-1:0] LAST = AW'(MAX_SIZE * MAX_SIZE - 1);

    sweep_state_t state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wb_addr, ram_waddr;
    logic [FIELD_W-1:0] ram_wdata, ram_qa, ram_qb;
    logic accept, wb_ok, rd_ok, ram_we, re_a;
    logic ack_q, wb_oor_q, rd_oor_q;
    logic unused_wb;

    assign wb_addr = slave.adr_o[AW-1:0];
    assign unused_wb = ^{slave.adr_o[ADR_W-1:AW],
                         slave.dat_o[DAT_W-1:FIELD_W]};

    assign wb_ok = ({1'b0, wb_addr[AW-1:IDX_W]} < board_size)
                && ({1'b0, wb_addr[IDX_W-1:0]} < board_size);
    assign rd_ok = ({1'b0, rd_row} < board_size)
                && ({1'b0, rd_col} < board_size);

    assign busy = (state_q == S_CLEAR);
    assign slave.stall_i = busy | clear_req;
    assign accept = slave.cyc_o & slave.stb_o & ~slave.stall_i;
    assign re_a = accept & ~slave.we_o;

    // Stall keeps the bus off the write port while the sweep owns it.
    assign ram_we = busy | (accept & slave.we_o & wb_ok);
    assign ram_waddr = busy ? cnt_q : wb_addr;
    assign ram_wdata = busy ? '0 : slave.dat_o[FIELD_W-1:0];

    assign slave.ack_i = ack_q;
    assign slave.dat_i = DAT_W'(wb_oor_q ? '0 : ram_qa);
    assign rd_data = rd_oor_q ? '0 : ram_qb;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    state_d = S_CLEAR;
                    cnt_d = '0;
                end
            end
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            cnt_q <= '0;
            ack_q <= 1'b0;
            wb_oor_q <= 1'b0;
            rd_oor_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            ack_q <= accept;
            if (re_a) begin
                wb_oor_q <= ~wb_ok;
            end
            rd_oor_q <= ~rd_ok;
        end
    end

    board_mem_ram #(
        .AW(AW),
        .DW(FIELD_W)
    ) u_ram (
        .clk(clk),
        .rst(rst),
        .we(ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .re_a(re_a),
        .raddr_a(wb_addr),
        .rdata_a(ram_qa),
        .raddr_b({rd_row, rd_col}),
        .rdata_b(ram_qb)
    );
endmodule

// File: tb/tb_wishbone_board_mem_dp.sv
// Directed bench for the dual-port board memory.
// Vector table for single accesses plus hand sequences for sweep cases.
module tb_wishbone_board_mem_dp;
    import wishbone_board_mem_dp_pkg::*;

    typedef struct {
        logic        we;
        logic [7:0]  adr;
        logic [15:0] dat;
        logic [4:0]  bs;
        logic [15:0] exp_dat;
        logic [7:0]  exp_rd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] board_size;
    logic clear_req;
    logic [3:0] rd_row, rd_col;
    logic [7:0] rd_data;
    logic busy;

    int npass = 0;
    int ntot = 0;

    wishbone_if #(.ADR_W(32), .DAT_W(16)) wb();

    wishbone_board_mem_dp #(
        .MAX_SIZE(16),
        .FIELD_W(8),
        .DAT_W(16),
        .ADR_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .slave(wb),
        .board_size(board_size),
        .clear_req(clear_req),
        .rd_row(rd_row),
        .rd_col(rd_col),
        .rd_data(rd_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic bus(input logic s, input logic w, input logic [7:0] a,
                       input logic [15:0] d);
        wb.cyc_o = s;
        wb.stb_o = s;
        wb.we_o = w;
        wb.adr_o = 32'(a);
        wb.dat_o = d;
    endtask

    vec_t vecs[16];
    logic [15:0] last_rd;
    logic [7:0] a8;
    int n, bad, acks, stalls;

    initial begin
        vecs[0]  = '{1, 8'h35, 16'h002A, 5'd16, 16'h0000, 8'h2A};
        vecs[1]  = '{0, 8'h35, 16'h0000, 5'd16, 16'h002A, 8'h2A};
        vecs[2]  = '{1, 8'h00, 16'hAB55, 5'd16, 16'h0000, 8'h55};
        vecs[3]  = '{0, 8'h00, 16'h0000, 5'd16, 16'h0055, 8'h55};
        vecs[4]  = '{1, 8'hFF, 16'h0077, 5'd16, 16'h0000, 8'h77};
        vecs[5]  = '{0, 8'hFF, 16'h0000, 5'd16, 16'h0077, 8'h77};
        vecs[6]  = '{1, 8'h9A, 16'h0011, 5'd8,  16'h0000, 8'h00};
        vecs[7]  = '{0, 8'h9A, 16'h0000, 5'd8,  16'h0000, 8'h00};
        vecs[8]  = '{0, 8'h9A, 16'h0000, 5'd16, 16'h0000, 8'h00};
        vecs[9]  = '{0, 8'h35, 16'h0000, 5'd8,  16'h002A, 8'h2A};
        vecs[10] = '{0, 8'hFF, 16'h0000, 5'd8,  16'h0000, 8'h00};
        vecs[11] = '{1, 8'h77, 16'h003C, 5'd8,  16'h0000, 8'h3C};
        vecs[12] = '{1, 8'h78, 16'h00C3, 5'd8,  16'h0000, 8'h00};
        vecs[13] = '{0, 8'h78, 16'h0000, 5'd16, 16'h0000, 8'h00};
        vecs[14] = '{0, 8'h00, 16'h0000, 5'd1,  16'h0055, 8'h55};
        vecs[15] = '{0, 8'h01, 16'h0000, 5'd1,  16'h0000, 8'h00};

        bus(0, 0, 8'h00, 16'h0000);
        board_size = 5'd16;
        clear_req = 1'b0;
        rd_row = 4'd0;
        rd_col = 4'd0;
        repeat (3) tick;

        // Reset state
        chk("rst_busy", busy, 1);
        chk("rst_ack", wb.ack_i, 0);
        chk("rst_dat", wb.dat_i, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_stall", wb.stall_i, 1);

        // Sweep after reset release
        rst = 1'b0;
        n = 0;
        stalls = 0;
        while (busy === 1'b1 && n < 1000) begin
            if (wb.stall_i !== 1'b1) stalls++;
            tick;
            n++;
        end
        chk("rst_sweep_len", n, 256);
        chk("rst_sweep_stall", stalls, 0);

        bad = 0;
        for (int i = 0; i < 256; i++) begin
            a8 = 8'(i);
            rd_row = a8[7:4];
            rd_col = a8[3:0];
            tick;
            if (rd_data !== 8'h00) bad++;
        end
        chk("clear_all_cells", bad, 0);

        bus(1, 0, 8'h00, 16'h0000);
        chk("first_rd_no_early_ack", wb.ack_i, 0);
        tick;
        chk("first_rd_ack", wb.ack_i, 1);
        chk("first_rd_dat", wb.dat_i, 0);
        bus(0, 0, 8'h00, 16'h0000);
        tick;
        chk("first_rd_ack_drop", wb.ack_i, 0);

        // Table of single accesses
        last_rd = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            board_size = vecs[i].bs;
            a8 = vecs[i].adr;
            rd_row = a8[7:4];
            rd_col = a8[3:0];
            bus(1, vecs[i].we, vecs[i].adr, vecs[i].dat);
            tick;
            bus(0, 0, 8'h00, 16'h0000);
            chk($sformatf("vec%0d_ack", i), wb.ack_i, 1);
            if (!vecs[i].we) last_rd = vecs[i].exp_dat;
            chk($sformatf("vec%0d_dat", i), wb.dat_i, last_rd);
            tick;
            chk($sformatf("vec%0d_ack_drop", i), wb.ack_i, 0);
            chk($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_rd);
        end

        // Back-to-back writes and reads
        board_size = 5'd16;
        acks = 0;
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            bus(1, 1, 8'(8'h40 + i), 16'(16'h10 + i));
            if (wb.stall_i !== 1'b0) stalls++;
            tick;
            if (wb.ack_i === 1'b1) acks++;
        end
        bus(0, 0, 8'h00, 16'h0000);
        tick;
        chk("b2b_wr_acks", acks, 8);
        chk("b2b_wr_ack_drop", wb.ack_i, 0);

        acks = 0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            bus(1, 0, 8'(8'h40 + i), 16'h0000);
            if (wb.stall_i !== 1'b0) stalls++;
            tick;
            if (wb.ack_i === 1'b1) acks++;
            if (wb.dat_i !== 16'(16'h10 + i)) bad++;
        end
        bus(0, 0, 8'h00, 16'h0000);
        tick;
        chk("b2b_rd_acks", acks, 8);
        chk("b2b_rd_data", bad, 0);
        chk("b2b_stalls", stalls, 0);
        chk("b2b_rd_ack_drop", wb.ack_i, 0);

        // Fill with 0xFF, then clear with a request in the same cycle
        for (int i = 0; i < 256; i++) begin
            bus(1, 1, 8'(i), 16'h00FF);
            tick;
        end
        chk("fill_last_ack", wb.ack_i, 1);
        rd_row = 4'd15;
        rd_col = 4'd15;
        bus(1, 0, 8'h35, 16'h0000);
        clear_req = 1'b1;
        #1;
        chk("clr_req_stall", wb.stall_i, 1);
        tick;
        clear_req = 1'b0;
        chk("clr_no_accept", wb.ack_i, 0);
        n = 0;
        acks = 0;
        stalls = 0;
        while (busy === 1'b1 && n < 1000) begin
            if (n == 128) chk("clr_partial", rd_data, 8'hFF);
            if (wb.stall_i !== 1'b1) stalls++;
            tick;
            if (wb.ack_i === 1'b1) acks++;
            n++;
        end
        chk("clr_sweep_len", n, 256);
        chk("clr_no_acks", acks, 0);
        chk("clr_stall", stalls, 0);
        tick;
        bus(0, 0, 8'h00, 16'h0000);
        chk("clr_held_ack", wb.ack_i, 1);
        chk("clr_held_dat", wb.dat_i, 0);

        // Reset at sweep count 100, clear_req ignored mid-sweep
        clear_req = 1'b1;
        tick;
        clear_req = 1'b0;
        for (int i = 0; i < 100; i++) tick;
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_rst_busy", busy, 1);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            clear_req = (n == 50);
            tick;
            n++;
        end
        clear_req = 1'b0;
        chk("mid_rst_sweep_len", n, 256);

        // Same-cycle write and display read of (2,2)
        rd_row = 4'd2;
        rd_col = 4'd2;
        bus(1, 1, 8'h22, 16'h005A);
        tick;
        bus(0, 0, 8'h00, 16'h0000);
        chk("rdw_ack", wb.ack_i, 1);
        chk("rdw_old", rd_data, 8'h00);
        tick;
        chk("rdw_new", rd_data, 8'h5A);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
